// File: rtl/reset_sequencer.sv
// reset_sequencer
// Debounces a board push-button and sequences CHANNELS reset domains out of
// reset one at a time, in index order, STAGE_DELAY cycles apart.
//
// Ports:
//   Clk          system clock, all logic on the rising edge
//   Reset        synchronous active-high global reset (restarts the sequence)
//   Button       raw asynchronous push-button, active-high
//   Kick         watchdog service strobe (only used with the watchdog build)
//   DomainReset  per-domain reset, active-high; bit i is high while i >= Stage
//   Stage        number of domains released so far (saturates at CHANNELS)
//   Done         high once every domain is released
//   WdFired      one-cycle pulse when the watchdog restarts the sequence
//
// Build option:
//   RESET_SEQ_WATCHDOG_EN  when defined, a watchdog running in DONE restarts
//                          the sequence if Kick is not seen for WD_TIMEOUT
//                          cycles. When undefined, Kick is ignored and
//                          WdFired stays 0.

module reset_sequencer #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned COUNT_WIDTH     = 19,
    parameter int unsigned STAGE_DELAY     = 524287,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WD_TIMEOUT      = 1048576
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                Button,
    input  logic                                Kick,
    output logic [CHANNELS-1:0]                 DomainReset,
    output logic [$clog2(CHANNELS+1)-1:0]       Stage,
    output logic                                Done,
    output logic                                WdFired
);

    localparam int unsigned STAGE_W = $clog2(CHANNELS + 1);
    localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [COUNT_WIDTH-1:0] STAGE_LAST     = COUNT_WIDTH'(STAGE_DELAY - 1);
    localparam logic [STAGE_W-1:0]     STAGE_FULL     = STAGE_W'(CHANNELS);
    localparam logic [STAGE_W-1:0]     STAGE_LAST_IDX = STAGE_W'(CHANNELS - 1);
    localparam logic [DEB_W-1:0]       DEB_LAST       = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Button synchroniser and debouncer
    logic [1:0]       sync_q;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] db_cnt_q, db_cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Sequencer
    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [STAGE_W-1:0]     stage_q, stage_d;
    logic [CHANNELS-1:0]    dr_q, dr_d;
    logic                   done_q, done_d;
    logic                   wdf_q, wdf_d;
    logic                   wd_expire_c;

    // Debounced level flips after DEBOUNCE_CYCLES consecutive differing samples;
    // any matching sample restarts the count. Edges are registered as pulses.
    always_comb begin
        db_cnt_d = '0;
        deb_d    = deb_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync_q[1] != deb_q) begin
            if (db_cnt_q == DEB_LAST) begin
                deb_d  = sync_q[1];
                rise_d = sync_q[1];
                fall_d = ~sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + DEB_W'(1);
            end
        end
    end

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = (WD_TIMEOUT > 1) ? $clog2(WD_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_TIMEOUT - 1);

    logic [WD_W-1:0] wd_q, wd_d;

    assign wd_expire_c = (state_q == ST_DONE) && (wd_q == WD_LAST) && !Kick;

    // Watchdog only counts while staying in DONE; anything else clears it.
    always_comb begin
        wd_d = '0;
        if ((state_q == ST_DONE) && (state_d == ST_DONE) && !Kick) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_wd;
    assign unused_wd   = ^{Kick, 32'(WD_TIMEOUT)};
    assign wd_expire_c = 1'b0;
`endif

    // Next-state and outputs: rising edge > watchdog expiry > stage advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        wdf_d   = 1'b0;
        dr_d    = '1;
        done_d  = 1'b0;

        if (rise_q) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            stage_d = '0;
        end else if (wd_expire_c) begin
            state_d = ST_COUNT;
            cnt_d   = '0;
            stage_d = '0;
            wdf_d   = 1'b1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    cnt_d   = '0;
                    stage_d = '0;
                    if (fall_q) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_d = '0;
                        if (stage_q != STAGE_FULL) begin
                            stage_d = stage_q + STAGE_W'(1);
                        end
                        if (stage_q == STAGE_LAST_IDX) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + COUNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    // counter frozen, nothing to do until restart
                end
                default: begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            endcase
        end

        // Domain i stays in reset until i domains below it have been released.
        for (int i = 0; i < int'(CHANNELS); i++) begin
            dr_d[i] = (STAGE_W'(i) >= stage_d);
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q   <= '0;
            deb_q    <= 1'b0;
            db_cnt_q <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            state_q  <= ST_COUNT;
            cnt_q    <= '0;
            stage_q  <= '0;
            dr_q     <= '1;
            done_q   <= 1'b0;
            wdf_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], Button};
            deb_q    <= deb_d;
            db_cnt_q <= db_cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            dr_q     <= dr_d;
            done_q   <= done_d;
            wdf_q    <= wdf_d;
        end
    end

    assign DomainReset = dr_q;
    assign Stage       = stage_q;
    assign Done        = done_q;
    assign WdFired     = wdf_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (STAGE_DELAY 4 and 1) share the
// same stimulus; a timeline model predicts outputs every cycle and a few
// hand-computed points pin the model.
module tb_reset_sequencer;

    localparam int unsigned CH   = 3;
    localparam int unsigned CW   = 4;
    localparam int unsigned DEB  = 4;
    localparam int unsigned WD   = 8;
    localparam int unsigned SD_A = 4;
    localparam int unsigned SD_B = 1;
    localparam int unsigned SW   = $clog2(CH + 1);
    localparam int          NI   = 2;

    logic clk = 1'b0;
    logic rst, btn, kick;
    logic [CH-1:0] dr_a, dr_b;
    logic [SW-1:0] st_a, st_b;
    logic          done_a, done_b, wdf_a, wdf_b;

    always #5 clk = ~clk;

    reset_sequencer #(.CHANNELS(CH), .COUNT_WIDTH(CW), .STAGE_DELAY(SD_A),
                      .DEBOUNCE_CYCLES(DEB), .WD_TIMEOUT(WD)) u_dut_a (
        .Clk(clk), .Reset(rst), .Button(btn), .Kick(kick),
        .DomainReset(dr_a), .Stage(st_a), .Done(done_a), .WdFired(wdf_a));

    reset_sequencer #(.CHANNELS(CH), .COUNT_WIDTH(CW), .STAGE_DELAY(SD_B),
                      .DEBOUNCE_CYCLES(DEB), .WD_TIMEOUT(WD)) u_dut_b (
        .Clk(clk), .Reset(rst), .Button(btn), .Kick(kick),
        .DomainReset(dr_b), .Stage(st_b), .Done(done_b), .WdFired(wdf_b));

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- timeline model ----------------
    // Period e = the cycle after rising edge e.
    int  cyc      = 0;
    int  rst_edge = 0;
    bit  seen_rst = 1'b0;
    bit  btn_hist [0:4095];
    bit  deb = 1'b0, rise_p = 1'b0, fall_p = 1'b0;
    bit  mode_hold [NI];
    int  t_start   [NI];
    int  last_kick [NI];
    bit  fired     [NI];

    function automatic int sd_of(input int i);
        return (i == 0) ? int'(SD_A) : int'(SD_B);
    endfunction

    function automatic int exp_stage(input int i, input int p);
        int s;
        if (mode_hold[i]) return 0;
        s = (p - t_start[i]) / sd_of(i);
        return (s > int'(CH)) ? int'(CH) : s;
    endfunction

    // Synchronised button value the debouncer sees at edge ee.
    function automatic bit samp(input int ee);
        if (ee - 2 <= rst_edge) return 1'b0;
        return btn_hist[ee - 2];
    endfunction

    // Debounced level flips at edge e when the last DEB samples all differ.
    function automatic bit flips(input int e);
        for (int k = 0; k < int'(DEB); k++) begin
            if (e - k <= rst_edge) return 1'b0;
            if (samp(e - k) == deb) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cmp_inst(input int i, input logic [CH-1:0] dr, input logic [SW-1:0] st,
                            input logic dn, input logic wf, input int p);
        int s;
        logic [CH-1:0] edr;
        logic edn;
        s   = exp_stage(i, p);
        edr = '1;
        for (int j = 0; j < int'(CH); j++) edr[j] = (j >= s);
        edn = !mode_hold[i] && (s == int'(CH));
        n_cmp++;
        if (dr !== edr || int'(st) != s || dn !== edn || wf !== fired[i]) begin
            n_bad++;
            $display("FAIL model_%0d @%0d: got dr=%b stage=%0d done=%b wdf=%b, expected dr=%b stage=%0d done=%b wdf=%b",
                     i, p, dr, st, dn, wf, edr, s, edn, fired[i]);
        end
    endtask

    initial begin : model_proc
        int  e;
        bit  r_in, b_in, k_in;
        forever begin
            @(posedge clk);
            cyc++;
            e    = cyc;
            r_in = rst;
            b_in = btn;
            k_in = kick;
            btn_hist[e] = b_in;
            if (r_in) begin
                seen_rst = 1'b1;
                rst_edge = e;
                deb      = 1'b0;
                rise_p   = 1'b0;
                fall_p   = 1'b0;
                for (int i = 0; i < NI; i++) begin
                    mode_hold[i] = 1'b0;
                    t_start[i]   = e;
                    fired[i]     = 1'b0;
                end
            end else begin
                for (int i = 0; i < NI; i++) begin
                    fired[i] = 1'b0;
                    if (rise_p) begin
                        mode_hold[i] = 1'b1;
                    end else if (mode_hold[i]) begin
                        if (fall_p) begin
                            mode_hold[i] = 1'b0;
                            t_start[i]   = e;
                        end
                    end
`ifdef RESET_SEQ_WATCHDOG_EN
                    else if (exp_stage(i, e - 1) == int'(CH)) begin
                        int done_start, base;
                        done_start = t_start[i] + int'(CH) * sd_of(i);
                        base = (last_kick[i] > done_start) ? last_kick[i] : done_start;
                        if ((e - 1) - base == int'(WD) - 1 && !k_in) begin
                            t_start[i] = e;
                            fired[i]   = 1'b1;
                        end else if (k_in) begin
                            last_kick[i] = e;
                        end
                    end
`endif
                end
                if (flips(e)) begin
                    deb    = !deb;
                    rise_p = deb;
                    fall_p = !deb;
                end else begin
                    rise_p = 1'b0;
                    fall_p = 1'b0;
                end
            end
            @(negedge clk);
            if (seen_rst) begin
                cmp_inst(0, dr_a, st_a, done_a, wdf_a, e);
                cmp_inst(1, dr_b, st_b, done_b, wdf_b, e);
            end
        end
    end

    // ---------------- hand-computed points ----------------
    task automatic lit(input string name, input int inst, input logic [CH-1:0] edr,
                       input int est, input logic edn);
        logic [CH-1:0] dr;
        logic [SW-1:0] st;
        logic dn;
        dr = (inst == 0) ? dr_a : dr_b;
        st = (inst == 0) ? st_a : st_b;
        dn = (inst == 0) ? done_a : done_b;
        n_cmp++;
        if (dr !== edr || int'(st) != est || dn !== edn) begin
            n_bad++;
            $display("FAIL %s: got dr=%b stage=%0d done=%b, expected dr=%b stage=%0d done=%b",
                     name, dr, st, dn, edr, est, edn);
        end
    endtask

    task automatic lit_wdf(input string name, input logic exp_v);
        n_cmp++;
        if (wdf_a !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got WdFired=%b, expected %b", name, wdf_a, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        for (int i = 0; i < NI; i++) last_kick[i] = 0;
        rst = 1'b1; btn = 1'b0; kick = 1'b0;
        tick(3);
        rst = 1'b0;
        // Plain sequence from reset release (this period is t0)
        lit("rst_state_a", 0, 3'b111, 0, 1'b0);
        lit("rst_state_b", 1, 3'b111, 0, 1'b0);
        tick(1); lit("sd1_k1", 1, 3'b110, 1, 1'b0);
        tick(1); lit("sd1_k2", 1, 3'b100, 2, 1'b0);
        tick(1); lit("sd1_k3", 1, 3'b000, 3, 1'b1);
                 lit("sd4_k3", 0, 3'b111, 0, 1'b0);
        tick(1); lit("sd4_k4", 0, 3'b110, 1, 1'b0);
        tick(4); lit("sd4_k8", 0, 3'b100, 2, 1'b0);
        tick(3); lit("sd4_k11", 0, 3'b100, 2, 1'b0);
        tick(1); lit("sd4_k12", 0, 3'b000, 3, 1'b1);

        // Short glitch on the button must be ignored
        btn = 1'b1; tick(3); btn = 1'b0;
        tick(10);
`ifndef RESET_SEQ_WATCHDOG_EN
        lit("glitch_ignored", 0, 3'b000, 3, 1'b1);
`endif

        // Press mid-sequence, hold, release
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(5);
        btn = 1'b1;
        tick(6); lit("press_minus1", 0, 3'b100, 2, 1'b0);
        tick(1); lit("press_hold_a", 0, 3'b111, 0, 1'b0);
                 lit("press_hold_b", 1, 3'b111, 0, 1'b0);
        tick(3);
        btn = 1'b0;
        tick(7); lit("release_t0", 0, 3'b111, 0, 1'b0);
        tick(1); lit("release_b1", 1, 3'b110, 1, 1'b0);
        tick(3); lit("release_a4", 0, 3'b110, 1, 1'b0);
        tick(10);

        // Reset on the same edge as the 1->2 advance
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(7);
        rst = 1'b1;
        tick(1); lit("reset_wins", 0, 3'b111, 0, 1'b0);
        rst = 1'b0;
        tick(14);

        // Kicks in DONE, then silence
        for (int k = 0; k < 4; k++) begin
            kick = 1'b1; tick(1); kick = 1'b0; tick(4);
        end
`ifdef RESET_SEQ_WATCHDOG_EN
        tick(3); lit_wdf("wd_not_yet", 1'b0);
        tick(1); lit_wdf("wd_fired", 1'b1);
                 lit("wd_restart", 0, 3'b111, 0, 1'b0);
        tick(16);
`else
        tick(20);
        lit_wdf("wd_absent", 1'b0);
        lit("wd_absent_done", 0, 3'b000, 3, 1'b1);
`endif
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
